// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: LSU priority with bounded IFU starvation.
// One outstanding transaction, registered request fields and response pulses.
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            own_lsu_q, own_lsu_d;
  logic            we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic            irv_q, irv_d;
  logic            lrv_q, lrv_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic [DATA_W-1:0] lrd_q, lrd_d;
  logic            gnt_lsu, gnt_ifu;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    gnt_lsu = 1'b0;
    gnt_ifu = 1'b0;
    if (rst_n && state_q == S_IDLE) begin
      gnt_lsu = lsu_req_valid &&
                ((starve_q < SMAX) || !ifu_req_valid);
      gnt_ifu = ifu_req_valid && !gnt_lsu;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    own_lsu_d = own_lsu_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    irv_d     = 1'b0;
    lrv_d     = 1'b0;
    ird_d     = ird_q;
    lrd_d     = lrd_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          gnt_lsu: begin
            state_d   = S_REQ;
            own_lsu_d = 1'b1;
            we_d      = lsu_we;
            addr_d    = lsu_addr;
            wdata_d   = lsu_wdata;
            wmask_d   = lsu_wmask;
            if (ifu_req_valid && starve_q != SMAX)
              starve_d = starve_q + CW'(1);
          end
          gnt_ifu: begin
            state_d   = S_REQ;
            own_lsu_d = 1'b0;
            we_d      = 1'b0;
            addr_d    = ifu_addr;
            wdata_d   = '0;
            wmask_d   = '0;
            starve_d  = '0;
          end
          default: ;
        endcase
      end
      S_REQ: begin
        if (mem_req_ready)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (own_lsu_q) begin
            lrv_d = 1'b1;
            if (!we_q)
              lrd_d = mem_rdata;
          end else begin
            irv_d = 1'b1;
            ird_d = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      own_lsu_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      irv_q     <= 1'b0;
      lrv_q     <= 1'b0;
      ird_q     <= '0;
      lrd_q     <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      own_lsu_q <= own_lsu_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      irv_q     <= irv_d;
      lrv_q     <= lrv_d;
      ird_q     <= ird_d;
      lrd_q     <= lrd_d;
    end
  end

  assign ifu_req_ready  = gnt_ifu;
  assign lsu_req_ready  = gnt_lsu;
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = irv_q;
  assign lsu_resp_valid = lrv_q;
  assign ifu_rdata      = ird_q;
  assign lsu_rdata      = lrd_q;

endmodule
